// File: rtl/cluster_pwr_seq.sv
// cluster_pwr_seq: orders cluster power switch, clock gate, isolation, reset and fetch enable with ack handshake and timeout
module cluster_pwr_seq #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       HCLK,
  input  logic       HRESET,
  input  logic       pow_req_i,
  input  logic       byp_i,
  input  logic       rstn_req_i,
  input  logic       fetch_req_i,
  input  logic [7:0] dly_cfg_i,
  input  logic       pwr_ack_i,
  output logic       pwr_en_o,
  output logic       clk_en_o,
  output logic       iso_o,
  output logic       cluster_rstn_o,
  output logic       fetch_en_o,
  output logic       busy_o,
  output logic       err_o,
  output logic [3:0] state_o
);
  typedef enum logic [3:0] {
    OFF      = 4'd0,
    PWR_UP   = 4'd1,
    CLK_ON   = 4'd2,
    ISO_OFF  = 4'd3,
    RST_WAIT = 4'd4,
    RUN      = 4'd5,
    ISO_ON   = 4'd6,
    CLK_OFF  = 4'd7,
    PWR_DN   = 4'd8,
    ERR      = 4'd9
  } state_t;
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
  state_t                 state, nxt;
  logic [15:0]            cnt, cnt_n;
  logic [SYNC_STAGES-1:0] sync;
  logic                   ack_s, tmo;
  assign ack_s   = sync[SYNC_STAGES-1];
  assign tmo     = cnt == TMO_LAST;
  assign state_o = state;
  // cnt serves both as the ack timeout and as the reset-release countdown
  always_comb begin
    nxt   = state;
    cnt_n = cnt;
    case (state)
      OFF: begin
        nxt   = pow_req_i ? PWR_UP : OFF;
        cnt_n = pow_req_i ? 16'd0 : cnt;
      end
      PWR_UP: begin
        nxt   = (ack_s || byp_i) ? CLK_ON : tmo ? ERR : PWR_UP;
        cnt_n = cnt + 16'd1;
      end
      CLK_ON:  nxt = ISO_OFF;
      ISO_OFF: begin
        nxt   = RST_WAIT;
        cnt_n = {8'd0, dly_cfg_i};
      end
      RST_WAIT: begin
        nxt   = (cnt == 16'd0) ? RUN : RST_WAIT;
        cnt_n = (cnt == 16'd0) ? cnt : cnt - 16'd1;
      end
      RUN:     nxt = pow_req_i ? RUN : ISO_ON;
      ISO_ON:  nxt = CLK_OFF;
      CLK_OFF: begin
        nxt   = PWR_DN;
        cnt_n = 16'd0;
      end
      PWR_DN: begin
        nxt   = (!ack_s || byp_i) ? OFF : tmo ? ERR : PWR_DN;
        cnt_n = cnt + 16'd1;
      end
      ERR:     nxt = pow_req_i ? ERR : OFF;
      default: nxt = OFF;
    endcase
  end
  // outputs decode the next state so they change on the same edge as the state register
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state          <= OFF;
      cnt            <= '0;
      sync           <= '0;
      pwr_en_o       <= 1'b0;
      clk_en_o       <= 1'b0;
      iso_o          <= 1'b1;
      cluster_rstn_o <= 1'b0;
      fetch_en_o     <= 1'b0;
      busy_o         <= 1'b0;
      err_o          <= 1'b0;
    end else begin
      state          <= nxt;
      cnt            <= cnt_n;
      sync           <= {sync[SYNC_STAGES-2:0], pwr_ack_i};
      pwr_en_o       <= nxt inside {PWR_UP, CLK_ON, ISO_OFF, RST_WAIT, RUN, ISO_ON, CLK_OFF};
      clk_en_o       <= nxt inside {CLK_ON, ISO_OFF, RST_WAIT, RUN, ISO_ON};
      iso_o          <= !(nxt inside {ISO_OFF, RST_WAIT, RUN});
      cluster_rstn_o <= (nxt == RUN) && rstn_req_i;
      fetch_en_o     <= (nxt == RUN) && rstn_req_i && fetch_req_i;
      busy_o         <= !(nxt inside {OFF, RUN, ERR});
      err_o          <= nxt == ERR;
    end
  end
endmodule

// File: tb/tb_cluster_pwr_seq.sv
// tb_cluster_pwr_seq: directed and random stimulus checked every cycle against a phase/age reference model
module tb_cluster_pwr_seq;
  localparam int T = 16;
  localparam int S = 2;
  logic       HCLK = 1'b0, HRESET = 1'b1;
  logic       pow_req_i = 1'b0, byp_i = 1'b1, rstn_req_i = 1'b0, fetch_req_i = 1'b0;
  logic [7:0] dly_cfg_i = 8'd0;
  logic       pwr_ack_i = 1'b0;
  logic       pwr_en_o, clk_en_o, iso_o, cluster_rstn_o, fetch_en_o, busy_o, err_o;
  logic [3:0] state_o;
  int n_chk = 0, n_fail = 0;
  int sw_mode = 0, ack_delay = 0, sw_cnt = 0;
  int n;

  always #5 HCLK = ~HCLK;

  cluster_pwr_seq #(.TIMEOUT_CYCLES(T), .SYNC_STAGES(S)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .pow_req_i(pow_req_i), .byp_i(byp_i),
    .rstn_req_i(rstn_req_i), .fetch_req_i(fetch_req_i), .dly_cfg_i(dly_cfg_i),
    .pwr_ack_i(pwr_ack_i), .pwr_en_o(pwr_en_o), .clk_en_o(clk_en_o), .iso_o(iso_o),
    .cluster_rstn_o(cluster_rstn_o), .fetch_en_o(fetch_en_o), .busy_o(busy_o),
    .err_o(err_o), .state_o(state_o)
  );

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // power switch: mode 0 follows pwr_en_o after ack_delay cycles, 1 stuck low, 2 stuck high
  always @(posedge HCLK) begin
    #2;
    if (sw_mode == 1) pwr_ack_i = 1'b0;
    else if (sw_mode == 2) pwr_ack_i = 1'b1;
    else if (pwr_ack_i != pwr_en_o) begin
      sw_cnt++;
      if (sw_cnt >= ack_delay) begin
        pwr_ack_i = pwr_en_o;
        sw_cnt = 0;
      end
    end else sw_cnt = 0;
  end

  // reference: phase number plus cycles spent in it; per-phase outputs {pwr,clk,iso,busy}
  localparam logic [3:0] TBL [10] = '{4'b0010, 4'b1011, 4'b1111, 4'b1101, 4'b1101,
                                      4'b1100, 4'b1111, 4'b1011, 4'b0011, 4'b0010};
  int   ph = 0, age = 0, rw_len = 0;
  logic m_r = 1'b0, m_f = 1'b0;
  logic hist [S] = '{default: 1'b0};

  always @(posedge HCLK or posedge HRESET) begin
    int   nph;
    logic a;
    if (HRESET) begin
      ph = 0; age = 0; m_r = 1'b0; m_f = 1'b0;
      for (int i = 0; i < S; i++) hist[i] = 1'b0;
    end else begin
      a = hist[S-1];
      for (int i = S - 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = pwr_ack_i;
      nph = ph;
      case (ph)
        0: if (pow_req_i) nph = 1;
        1: if (a || byp_i) nph = 2; else if (age == T - 1) nph = 9;
        2: nph = 3;
        3: begin rw_len = int'(dly_cfg_i); nph = 4; end
        4: if (age == rw_len) nph = 5;
        5: if (!pow_req_i) nph = 6;
        6: nph = 7;
        7: nph = 8;
        8: if (!a || byp_i) nph = 0; else if (age == T - 1) nph = 9;
        default: if (!pow_req_i) nph = 0;
      endcase
      age = (nph == ph) ? age + 1 : 0;
      m_r = rstn_req_i;
      m_f = rstn_req_i && fetch_req_i;
      ph = nph;
    end
  end

  always @(negedge HCLK) begin
    logic [3:0] e;
    e = TBL[ph];
    chk("state", int'(state_o), ph);
    chk("pwr_en", int'(pwr_en_o), int'(e[3]));
    chk("clk_en", int'(clk_en_o), int'(e[2]));
    chk("iso", int'(iso_o), int'(e[1]));
    chk("busy", int'(busy_o), int'(e[0]));
    chk("rstn", int'(cluster_rstn_o), int'(ph == 5 && m_r));
    chk("fetch", int'(fetch_en_o), int'(ph == 5 && m_f));
    chk("err", int'(err_o), int'(ph == 9));
    chk("inv_clk_pwr", int'(clk_en_o && !pwr_en_o), 0);
    chk("inv_iso_clk", int'(!iso_o && !clk_en_o), 0);
    chk("inv_rstn_iso", int'(cluster_rstn_o && iso_o), 0);
    chk("inv_fetch_rstn", int'(fetch_en_o && !cluster_rstn_o), 0);
  end

  task automatic wait_state(input int s, input int budget);
    int k = 0;
    while (int'(state_o) != s && k < budget) begin
      @(negedge HCLK);
      k++;
    end
    if (int'(state_o) != s) begin
      n_chk++;
      n_fail++;
      $display("FAIL wait_state: state %0d, expected %0d within %0d cycles", state_o, s, budget);
    end
  endtask

  task automatic dwell(input int s, input int budget, output int cnt);
    cnt = 0;
    while (int'(state_o) == s && cnt < budget) begin
      cnt++;
      @(negedge HCLK);
    end
  endtask

  task automatic cyc;
    @(posedge HCLK);
    #2;
  endtask

  initial begin
    repeat (3) @(posedge HCLK);
    #2 HRESET = 1'b0;
    @(negedge HCLK);
    chk("rst_state", int'(state_o), 0);
    chk("rst_iso", int'(iso_o), 1);
    chk("rst_pwr", int'(pwr_en_o), 0);
    // bypassed power-up, dly 3: seven busy cycles then RUN with reset and fetch released
    cyc();
    byp_i = 1'b1; dly_cfg_i = 8'd3; rstn_req_i = 1'b1; fetch_req_i = 1'b1; pow_req_i = 1'b1;
    n = 0;
    for (int k = 0; k < 40 && state_o != 4'd5; k++) begin
      @(negedge HCLK);
      if (busy_o) n++;
    end
    chk("t1_run", int'(state_o), 5);
    chk("t1_busy_cycles", n, 7);
    chk("t1_rstn", int'(cluster_rstn_o), 1);
    chk("t1_fetch", int'(fetch_en_o), 1);
    // software reset in RUN, then bypassed power-down
    cyc(); rstn_req_i = 1'b0;
    @(posedge HCLK); @(negedge HCLK);
    chk("t4_rstn", int'(cluster_rstn_o), 0);
    chk("t4_fetch", int'(fetch_en_o), 0);
    cyc(); pow_req_i = 1'b0;
    @(posedge HCLK); @(negedge HCLK);
    chk("t4_iso_on", int'(iso_o), 1);
    @(negedge HCLK);
    chk("t4_clk_off", int'(clk_en_o), 0);
    @(negedge HCLK);
    chk("t4_pwr_off", int'(pwr_en_o), 0);
    @(negedge HCLK);
    chk("t4_off", int'(state_o), 0);
    // real switch, ack 10 cycles after the enable edge
    cyc();
    byp_i = 1'b0; ack_delay = 10; sw_mode = 0; rstn_req_i = 1'b1; pow_req_i = 1'b1;
    wait_state(1, 20);
    dwell(1, 100, n);
    chk("t2_pwrup_dwell", n, 12);
    chk("t2_clk_on", int'(state_o), 2);
    wait_state(5, 60);
    cyc(); pow_req_i = 1'b0;
    wait_state(8, 20);
    dwell(8, 100, n);
    chk("t2_pwrdn_dwell", n, 12);
    chk("t2_off", int'(state_o), 0);
    // ack never rises: timeout into ERR, cleared by dropping the request
    cyc(); sw_mode = 1; pow_req_i = 1'b1;
    wait_state(1, 20);
    dwell(1, 100, n);
    chk("t3_up_timeout", n, T);
    chk("t3_err_state", int'(state_o), 9);
    chk("t3_err", int'(err_o), 1);
    chk("t3_pwr", int'(pwr_en_o), 0);
    cyc(); pow_req_i = 1'b0;
    @(posedge HCLK); @(negedge HCLK);
    chk("t3_off", int'(state_o), 0);
    chk("t3_err_clr", int'(err_o), 0);
    // ack stuck high: power-down timeout
    cyc(); sw_mode = 2; pow_req_i = 1'b1;
    wait_state(5, 60);
    cyc(); pow_req_i = 1'b0;
    wait_state(8, 20);
    dwell(8, 100, n);
    chk("t3_dn_timeout", n, T);
    chk("t3_dn_err", int'(err_o), 1);
    wait_state(0, 5);
    sw_mode = 0; ack_delay = 0; byp_i = 1'b1;
    repeat (4) cyc();
    // request dropped during RST_WAIT is ignored until RUN, then reset hits mid-sequence
    dly_cfg_i = 8'd20; pow_req_i = 1'b1;
    wait_state(4, 20);
    cyc(); pow_req_i = 1'b0;
    wait_state(5, 40);
    wait_state(0, 20);
    cyc(); pow_req_i = 1'b1;
    wait_state(2, 10);
    #1 HRESET = 1'b1;
    #1;
    chk("t5_state", int'(state_o), 0);
    chk("t5_pwr", int'(pwr_en_o), 0);
    chk("t5_clk", int'(clk_en_o), 0);
    chk("t5_iso", int'(iso_o), 1);
    chk("t5_rstn", int'(cluster_rstn_o), 0);
    chk("t5_fetch", int'(fetch_en_o), 0);
    chk("t5_busy", int'(busy_o), 0);
    chk("t5_err", int'(err_o), 0);
    cyc(); HRESET = 1'b0; pow_req_i = 1'b0;
    // reset-release delay extremes; dly changed mid-wait must not matter
    cyc(); dly_cfg_i = 8'd0; pow_req_i = 1'b1;
    wait_state(4, 20);
    dwell(4, 400, n);
    chk("t6_dly0", n, 1);
    pow_req_i = 1'b0;
    wait_state(0, 20);
    cyc(); dly_cfg_i = 8'd255; pow_req_i = 1'b1;
    wait_state(4, 20);
    dly_cfg_i = 8'd7;
    dwell(4, 400, n);
    chk("t6_dly255", n, 256);
    pow_req_i = 1'b0;
    wait_state(0, 20);
    // random traffic
    for (int i = 0; i < 4000; i++) begin
      cyc();
      if (i % 250 == 0) begin
        byp_i = ($urandom_range(0, 3) == 0);
        sw_mode = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 2)) : 0;
        ack_delay = int'($urandom_range(0, 20));
      end
      if ($urandom_range(0, 29) == 0) pow_req_i = ~pow_req_i;
      if ($urandom_range(0, 7) == 0) rstn_req_i = ~rstn_req_i;
      if ($urandom_range(0, 5) == 0) fetch_req_i = ~fetch_req_i;
      dly_cfg_i = 8'($urandom_range(0, 9));
      if ($urandom_range(0, 499) == 0) begin
        HRESET = 1'b1;
        #2 HRESET = 1'b0;
      end
    end
    @(negedge HCLK);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/cluster_pwr_seq.md
# cluster_pwr_seq

Cluster power-domain sequencer in the SoC control subsystem. It takes the software-level cluster requests held in the SoC control register file (power, bypass, reset, fetch enable). It drives the cluster power switch, clock gate, isolation cells, reset and fetch enable in a fixed, glitch-free order, with a power-good handshake and a timeout. A status word is returned for software readback.

## Interface
- `TIMEOUT_CYCLES`, default 1024: maximum cycles to wait for the power switch ack in either direction; legal range 4..65535.
- `SYNC_STAGES`, default 2: synchronizer depth on `pwr_ack_i`; legal range 2..3.

Ports:
- `HCLK`  in  1  SoC clock.
- `HRESET`  in  1  reset, asynchronous assert, active-high.
- `pow_req_i`  in  1  cluster power request (level, software register).
- `byp_i`  in  1  1 = power switch absent or bypassed; the ack wait is skipped.
- `rstn_req_i`  in  1  software cluster reset, 0 = hold the cluster in reset while RUN.
- `fetch_req_i`  in  1  software fetch enable.
- `dly_cfg_i`  in  8  reset-release delay in cycles after isolation drops.
- `pwr_ack_i`  in  1  power-good from the switch; asynchronous.
- `pwr_en_o`  out  1  power switch enable.
- `clk_en_o`  out  1  cluster clock gate enable.
- `iso_o`  out  1  isolation enable, 1 = isolated.
- `cluster_rstn_o`  out  1  cluster reset, active-low.
- `fetch_en_o`  out  1  cluster fetch enable.
- `busy_o`  out  1  sequence in progress.
- `err_o`  out  1  timeout flag, sticky.
- `state_o`  out  4  current state encoding, for the status register.

## Operation
- All outputs are flops, updated on the same edge as the state register. `pwr_ack_i` passes through a `SYNC_STAGES` flop synchronizer, giving `ack_s`.
- `pow_req_i`, `rstn_req_i` and `fetch_req_i` are acted on only in OFF, RUN and ERR. Changes during a transition sequence are ignored until that sequence ends.
- The 16-bit counter `cnt` is shared by the timeout and the reset delay.
- State encodings and outputs (`pwr_en`/`clk_en`/`iso`/`rstn`/`fetch`/`busy`):
  - OFF=0: 0/0/1/0/0/0. If `pow_req_i`=1, go to PWR_UP and clear `cnt`.
  - PWR_UP=1: 1/0/1/0/0/1. If `ack_s`=1 or `byp_i`=1, go to CLK_ON. Otherwise increment `cnt`; when `cnt`=`TIMEOUT_CYCLES`-1, go to ERR.
  - CLK_ON=2: 1/1/1/0/0/1. Always go to ISO_OFF.
  - ISO_OFF=3: 1/1/0/0/0/1. Load `cnt`=`dly_cfg_i`, go to RST_WAIT.
  - RST_WAIT=4: 1/1/0/0/0/1. Decrement `cnt`; when `cnt`=0, go to RUN.
  - RUN=5: 1/1/0/`rstn_req_i`/(`fetch_req_i`&`rstn_req_i`)/0. If `pow_req_i`=0, go to ISO_ON.
  - ISO_ON=6: 1/1/1/0/0/1. Always go to CLK_OFF.
  - CLK_OFF=7: 1/0/1/0/0/1. Clear `cnt`, go to PWR_DN.
  - PWR_DN=8: 0/0/1/0/0/1. If `ack_s`=0 or `byp_i`=1, go to OFF. Otherwise increment `cnt`; on timeout go to ERR.
  - ERR=9: 0/0/1/0/0/0, `err_o`=1. If `pow_req_i`=0, go to OFF and clear `err_o`.
- Ordering invariants. Check all of these every cycle:
  - `clk_en_o` implies `pwr_en_o`.
  - `iso_o`=0 implies `clk_en_o`.
  - `cluster_rstn_o`=1 implies `iso_o`=0.
  - `fetch_en_o`=1 implies `cluster_rstn_o`=1.
- Boundary behaviour:
  - `dly_cfg_i`=0 gives a single RST_WAIT cycle.
  - `dly_cfg_i` is sampled only in ISO_OFF.
  - Unused encodings 10..15 go to OFF on the next edge.
- `HRESET` mid-sequence forces every output to its OFF value immediately, without waiting for a clock. The synchronizer and `cnt` are cleared.

## Timing
- Reset values:
  - `pwr_en_o`, `clk_en_o`, `cluster_rstn_o`, `fetch_en_o`, `busy_o`, `err_o` = 0.
  - `iso_o` = 1.
  - `state_o` = 0.
- Power-up with `byp_i`=1: `pow_req_i` sampled high at edge E gives PWR_UP at E+1, CLK_ON at E+2, ISO_OFF at E+3, RST_WAIT at E+4, and RUN at E+5+`dly_cfg_i`.
- Power-up with a real switch: the PWR_UP dwell is the ack delay plus `SYNC_STAGES` cycles.
- Power-down with `byp_i`=1: `pow_req_i` sampled low in RUN at edge E gives ISO_ON at E+1, CLK_OFF at E+2, PWR_DN at E+3 and OFF at E+4.
- In RUN, `cluster_rstn_o` and `fetch_en_o` follow the request inputs with 1 cycle of latency.
- Timeout: ERR is entered exactly `TIMEOUT_CYCLES` cycles after entering PWR_UP or PWR_DN when no ack arrives.

## Test plan
- Reset, then `pow_req_i`=1, `byp_i`=1, `dly_cfg_i`=3, `rstn_req_i`=1, `fetch_req_i`=1 → RUN 8 cycles after the sampling edge; `cluster_rstn_o`=1 and `fetch_en_o`=1 in RUN; `busy_o` high for exactly 7 cycles.
- `byp_i`=0, `pwr_ack_i` rises 10 cycles after `pwr_en_o` → CLK_ON entered 10+2 cycles after `pwr_en_o`; the four ordering invariants hold every cycle.
- `byp_i`=0, `pwr_ack_i` held 0, `TIMEOUT_CYCLES`=16 → ERR after 16 cycles in PWR_UP; `err_o`=1, `pwr_en_o`=0; dropping `pow_req_i` → OFF and `err_o`=0.
- In RUN, toggle `rstn_req_i` to 0 with `fetch_req_i`=1 → `cluster_rstn_o`=0 and `fetch_en_o`=0 one cycle later; then drop `pow_req_i` → `iso_o`=1, `clk_en_o`=0 and `pwr_en_o`=0 on successive cycles, reaching OFF.
- Drop `pow_req_i` while in RST_WAIT → the sequence still reaches RUN, then powers down; assert `HRESET` in CLK_ON → all outputs at reset values before the next `HCLK` edge.
- `dly_cfg_i`=0 → exactly one RST_WAIT cycle; `dly_cfg_i`=255 → 256 RST_WAIT cycles.
